// File: rtl/fine_tap_encoder.sv
// Fine delay-line tap encoder: latches Start/Stop thermometer vectors, popcounts them one
// CARRY4 group per cycle and hands the counts over valid/ready. Bubble check: FINE_BUBBLE_CHECK_EN.
module fine_tap_encoder #(
   parameter int unsigned NUM  = 12,
   parameter int unsigned TAPW = $clog2(NUM + 1)
) (
   input  logic            clk,
   input  logic            iRst,
   input  logic [NUM-1:0]  iFFStart,
   input  logic [NUM-1:0]  iFFStop,
   input  logic            iStartCapture,
   input  logic            iStopCapture,
   input  logic            iReady,
   output logic            oValid,
   output logic [TAPW-1:0] oStartTaps,
   output logic [TAPW-1:0] oStopTaps,
   output logic            oBubble,
   output logic            oBusy,
   output logic            oDrop
);

   localparam int unsigned NGRP = NUM / 4;
   localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam logic [GW-1:0] LastGrp = GW'(NGRP - 1);

   typedef enum logic [1:0] {StIdle, StWaitStop, StCount, StHold} state_t;

   state_t          stateQ, stateD;
   logic [NUM-1:0]  startVecQ, startVecD;
   logic [NUM-1:0]  stopVecQ, stopVecD;
   logic [GW-1:0]   grpQ, grpD;
   logic [TAPW-1:0] startAccQ, startAccD;
   logic [TAPW-1:0] stopAccQ, stopAccD;
   logic            dropQ, dropD;

   logic [NUM-1:0]  startShift, stopShift;
   logic [3:0]      startNib, stopNib;

   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   assign startShift = startVecQ >> {grpQ, 2'b00};
   assign stopShift  = stopVecQ >> {grpQ, 2'b00};
   assign startNib   = startShift[3:0];
   assign stopNib    = stopShift[3:0];

`ifdef FINE_BUBBLE_CHECK_EN
   logic           bubQ, bubD;
   logic [NUM:0]   startExt, stopExt;
   logic [4:0]     startWin, stopWin;
   logic           grpBubble;

   // Bit below tap 0 reads as 1 so group 0 has no boundary bubble; the window
   // carries the previous group's bit 3 for the cross-group check.
   assign startExt  = {startVecQ, 1'b1} >> {grpQ, 2'b00};
   assign stopExt   = {stopVecQ, 1'b1} >> {grpQ, 2'b00};
   assign startWin  = startExt[4:0];
   assign stopWin   = stopExt[4:0];
   assign grpBubble = (|(startWin[4:1] & ~startWin[3:0])) | (|(stopWin[4:1] & ~stopWin[3:0]));
`endif

   always_comb begin
      stateD    = stateQ;
      startVecD = startVecQ;
      stopVecD  = stopVecQ;
      grpD      = grpQ;
      startAccD = startAccQ;
      stopAccD  = stopAccQ;
      dropD     = 1'b0;
`ifdef FINE_BUBBLE_CHECK_EN
      bubD      = bubQ;
`endif
      unique case (stateQ)
         StIdle: begin
            if (iStartCapture && iStopCapture) begin
               startVecD = iFFStart;
               stopVecD  = iFFStop;
               stateD    = StCount;
            end else if (iStartCapture) begin
               startVecD = iFFStart;
               stateD    = StWaitStop;
            end else if (iStopCapture) begin
               dropD = 1'b1;
            end
         end
         StWaitStop: begin
            if (iStartCapture) begin
               startVecD = iFFStart;
            end
            if (iStopCapture) begin
               stopVecD = iFFStop;
               stateD   = StCount;
            end
         end
         StCount: begin
            dropD     = iStartCapture | iStopCapture;
            startAccD = startAccQ + TAPW'(popcnt4(startNib));
            stopAccD  = stopAccQ + TAPW'(popcnt4(stopNib));
            grpD      = grpQ + 1'b1;
`ifdef FINE_BUBBLE_CHECK_EN
            bubD      = bubQ | grpBubble;
`endif
            if (grpQ == LastGrp) begin
               stateD = StHold;
            end
         end
         StHold: begin
            dropD = iStartCapture | iStopCapture;
            if (iReady) begin
               stateD = StIdle;
            end
         end
      endcase

      // Fresh measurement: clear the walk and the sums as COUNT is entered.
      if (stateQ != StCount && stateD == StCount) begin
         grpD      = '0;
         startAccD = '0;
         stopAccD  = '0;
`ifdef FINE_BUBBLE_CHECK_EN
         bubD      = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge iRst) begin
      if (!iRst) begin
         stateQ    <= StIdle;
         startVecQ <= '0;
         stopVecQ  <= '0;
         grpQ      <= '0;
         startAccQ <= '0;
         stopAccQ  <= '0;
         dropQ     <= 1'b0;
`ifdef FINE_BUBBLE_CHECK_EN
         bubQ      <= 1'b0;
`endif
      end else begin
         stateQ    <= stateD;
         startVecQ <= startVecD;
         stopVecQ  <= stopVecD;
         grpQ      <= grpD;
         startAccQ <= startAccD;
         stopAccQ  <= stopAccD;
         dropQ     <= dropD;
`ifdef FINE_BUBBLE_CHECK_EN
         bubQ      <= bubD;
`endif
      end
   end

   assign oValid     = (stateQ == StHold);
   assign oBusy      = (stateQ != StIdle);
   assign oStartTaps = startAccQ;
   assign oStopTaps  = stopAccQ;
   assign oDrop      = dropQ;
`ifdef FINE_BUBBLE_CHECK_EN
   assign oBubble    = (stateQ == StHold) & bubQ;
`else
   assign oBubble    = 1'b0;
`endif

endmodule
